led_auto_scheduler: RTL and testbench

- Arbitrates the user-LED number/brightness state between two requesters: the manual path (debounced, edge-detected button ticks) and an autonomous "breathing" demo sequencer.
- Drives number[3:0] (LED pattern) and brightness[2:0] (PWM mode 0..5). Sits between the button debounce/edge logic and the pwm generator/LED gating.
- After a configurable idle period with no button activity, control passes to the demo. The next button tick returns control to manual and restores the pre-demo state.

---
 rtl/led_auto_scheduler.sv | 174 +++++++++++++++++
 tb/tb_led_auto_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_auto_scheduler.sv
// led_auto_scheduler
// Arbitrates the user-LED number/brightness between manual button ticks and an
// autonomous "breathing" demo. After IDLE_STEPS step events without a tick the
// demo takes over; the next tick hands control back and restores the pre-demo
// number/brightness.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   dec_tick     one-cycle pulse, number -1
//   inc_tick     one-cycle pulse, number +1
//   dim_tick     one-cycle pulse, brightness -1
//   bright_tick  one-cycle pulse, brightness +1
//   number       signed LED value, -8..7
//   brightness   PWM mode, 0..MAX_LEVEL
//   auto_active  high while the demo owns the outputs
//   step_pulse   one-cycle pulse per step event
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_MANUAL    | ticks adjust number/brightness; idle counter runs
// ST_AUTO_UP   | demo ramps brightness up one level per step
// ST_AUTO_DOWN | demo ramps brightness down; at 0 bumps number and ramps up

module led_auto_scheduler #(
    parameter int STEP_CYCLES = 50000000,
    parameter int IDLE_STEPS  = 10,
    parameter int MAX_LEVEL   = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dec_tick,
    input  logic       inc_tick,
    input  logic       dim_tick,
    input  logic       bright_tick,
    output logic [3:0] number,
    output logic [2:0] brightness,
    output logic       auto_active,
    output logic       step_pulse
);

    localparam int PW = $clog2(STEP_CYCLES);
    localparam int IW = (IDLE_STEPS > 1) ? $clog2(IDLE_STEPS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_STEPS - 1);
    localparam logic [2:0]    MAX_B      = 3'(MAX_LEVEL);

    localparam logic [1:0] ST_MANUAL    = 2'd0;
    localparam logic [1:0] ST_AUTO_UP   = 2'd1;
    localparam logic [1:0] ST_AUTO_DOWN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [3:0]    number_q, number_d;
    logic [2:0]    bright_q, bright_d;
    logic [3:0]    shadow_num_q, shadow_num_d;
    logic [2:0]    shadow_bri_q, shadow_bri_d;
    logic          step_q, step_d;
    logic          auto_q, auto_d;

    logic       any_tick;
    logic       step_evt;
    logic [2:0] bright_inc;
    logic [2:0] bright_dec;

    assign any_tick   = dec_tick | inc_tick | dim_tick | bright_tick;
    assign step_evt   = (presc_q == PRESC_LAST);
    assign bright_inc = bright_q + 3'd1;
    assign bright_dec = bright_q - 3'd1;

    always_comb begin
        state_d      = state_q;
        idle_d       = idle_q;
        number_d     = number_q;
        bright_d     = bright_q;
        shadow_num_d = shadow_num_q;
        shadow_bri_d = shadow_bri_q;
        step_d       = step_evt;

        // Any tick restarts the step phase so idle time is measured from the tick.
        if (any_tick || step_evt) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        case (state_q)
            ST_MANUAL: begin
                if (any_tick) begin
                    idle_d = '0;
                    if (inc_tick && !dec_tick && number_q != 4'b0111) begin
                        number_d = number_q + 4'd1;
                    end else if (dec_tick && !inc_tick && number_q != 4'b1000) begin
                        number_d = number_q - 4'd1;
                    end
                    if (bright_tick && !dim_tick && bright_q != MAX_B) begin
                        bright_d = bright_inc;
                    end else if (dim_tick && !bright_tick && bright_q != 3'd0) begin
                        bright_d = bright_dec;
                    end
                end else if (step_evt) begin
                    if (idle_q == IDLE_LAST) begin
                        shadow_num_d = number_q;
                        shadow_bri_d = bright_q;
                        bright_d     = 3'd0;
                        idle_d       = '0;
                        state_d      = ST_AUTO_UP;
                    end else begin
                        idle_d = idle_q + IW'(1);
                    end
                end
            end
            ST_AUTO_UP, ST_AUTO_DOWN: begin
                // The exiting tick only restores; it is not applied as an adjustment.
                if (any_tick) begin
                    state_d  = ST_MANUAL;
                    number_d = shadow_num_q;
                    bright_d = shadow_bri_q;
                    idle_d   = '0;
                end else if (step_evt) begin
                    if (state_q == ST_AUTO_UP) begin
                        bright_d = bright_inc;
                        if (bright_inc == MAX_B) begin
                            state_d = ST_AUTO_DOWN;
                        end
                    end else begin
                        bright_d = bright_dec;
                        if (bright_dec == 3'd0) begin
                            number_d = number_q + 4'd1;  // natural 4-bit wrap 7 -> -8
                            state_d  = ST_AUTO_UP;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_MANUAL;
            end
        endcase

        auto_d = (state_d != ST_MANUAL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_MANUAL;
            presc_q      <= '0;
            idle_q       <= '0;
            number_q     <= 4'd0;
            bright_q     <= MAX_B;
            shadow_num_q <= 4'd0;
            shadow_bri_q <= 3'd0;
            step_q       <= 1'b0;
            auto_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            idle_q       <= idle_d;
            number_q     <= number_d;
            bright_q     <= bright_d;
            shadow_num_q <= shadow_num_d;
            shadow_bri_q <= shadow_bri_d;
            step_q       <= step_d;
            auto_q       <= auto_d;
        end
    end

    assign number      = number_q;
    assign brightness  = bright_q;
    assign auto_active = auto_q;
    assign step_pulse  = step_q;

endmodule

// File: tb/tb_led_auto_scheduler.sv
// Testbench for led_auto_scheduler with STEP_CYCLES=4, IDLE_STEPS=3, MAX_LEVEL=5.
// Directed steps walk through saturation, idle entry, breathing, exit/restore,
// tick/step collision and asynchronous reset, then a randomized tick stream is
// checked cycle by cycle against an integer reference model.

module tb_led_auto_scheduler;

    localparam int SC = 4;
    localparam int IS = 3;
    localparam int ML = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       dec_tick = 1'b0;
    logic       inc_tick = 1'b0;
    logic       dim_tick = 1'b0;
    logic       bright_tick = 1'b0;
    logic [3:0] number;
    logic [2:0] brightness;
    logic       auto_active;
    logic       step_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain integers following the behavioural rules.
    int m_num, m_bri, m_auto, m_up, m_pre, m_idle, m_sn, m_sb, m_step;

    led_auto_scheduler #(
        .STEP_CYCLES(SC),
        .IDLE_STEPS (IS),
        .MAX_LEVEL  (ML)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dec_tick   (dec_tick),
        .inc_tick   (inc_tick),
        .dim_tick   (dim_tick),
        .bright_tick(bright_tick),
        .number     (number),
        .brightness (brightness),
        .auto_active(auto_active),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_num = 0; m_bri = ML; m_auto = 0; m_up = 0;
        m_pre = 0; m_idle = 0; m_sn = 0; m_sb = 0; m_step = 0;
    endtask

    task automatic model_step(input bit i, input bit d, input bit m, input bit b);
        bit any;
        bit step;
        any  = i | d | m | b;
        step = (m_pre == SC - 1);
        m_step = int'(step);
        m_pre  = any ? 0 : (m_pre + 1) % SC;
        if (m_auto == 0) begin
            if (any) begin
                m_idle = 0;
                m_num  = clamp(m_num + int'(i) - int'(d), -8, 7);
                m_bri  = clamp(m_bri + int'(b) - int'(m), 0, ML);
            end else if (step) begin
                if (m_idle == IS - 1) begin
                    m_sn = m_num; m_sb = m_bri;
                    m_bri = 0; m_auto = 1; m_up = 1; m_idle = 0;
                end else begin
                    m_idle++;
                end
            end
        end else if (any) begin
            m_auto = 0; m_num = m_sn; m_bri = m_sb; m_idle = 0;
        end else if (step) begin
            if (m_up != 0) begin
                m_bri++;
                if (m_bri == ML) m_up = 0;
            end else begin
                m_bri--;
                if (m_bri == 0) begin
                    m_num = (m_num == 7) ? -8 : m_num + 1;
                    m_up  = 1;
                end
            end
        end
    endtask

    // Called just after an active edge: drive inputs, take one edge, check.
    task automatic cycle(input bit i, input bit d, input bit m, input bit b);
        inc_tick = i; dec_tick = d; dim_tick = m; bright_tick = b;
        @(posedge clk);
        model_step(i, d, m, b);
        #1;
        chk("number", 32'($signed(number)), m_num);
        chk("brightness", 32'(brightness), m_bri);
        chk("auto_active", 32'(auto_active), m_auto);
        chk("step_pulse", 32'(step_pulse), m_step);
        inc_tick = 1'b0; dec_tick = 1'b0; dim_tick = 1'b0; bright_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_number"}, 32'($signed(number)), 0);
        chk({tag, "_brightness"}, 32'(brightness), ML);
        chk({tag, "_auto"}, 32'(auto_active), 0);
        chk({tag, "_step"}, 32'(step_pulse), 0);
    endtask

    initial begin
        int seq [10] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0};
        int seen_auto;
        logic [3:0] p;
        int r;

        // Reset asserted mid-cycle, before any clock edge.
        #2 reset_n = 1'b0;
        #1 check_reset_values("rst_async");
        model_reset();
        @(posedge clk);
        #1 check_reset_values("rst_held");
        reset_n = 1'b1;

        // Number saturation.
        repeat (9) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("inc_sat", 32'($signed(number)), 7);
        repeat (16) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("dec_sat", 32'($signed(number)), -8);
        repeat (11) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("num_at_3", 32'($signed(number)), 3);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("inc_dec_hold", 32'($signed(number)), 3);

        // Brightness saturation.
        repeat (7) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("dim_sat", 32'(brightness), 0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bright_two", 32'(brightness), 2);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        chk("dim_bright_hold", 32'(brightness), 2);

        // Ticks 11 cycles apart never let the demo start.
        seen_auto = 0;
        repeat (4) begin
            repeat (10) begin
                cycle(1'b0, 1'b0, 1'b0, 1'b0);
                seen_auto |= int'(auto_active);
            end
            cycle(1'b0, 1'b0, 1'b1, 1'b1);
            seen_auto |= int'(auto_active);
        end
        chk("spaced_no_auto", 32'(seen_auto), 0);

        // Idle entry from number=6, brightness=2.
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_entry_num", 32'($signed(number)), 6);
        chk("pre_entry_bri", 32'(brightness), 2);
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            chk("entry_edge_auto", 32'(auto_active), int'(k == 12));
            chk("step_period", 32'(step_pulse), int'(k % 4 == 0));
        end
        chk("entry_bri", 32'(brightness), 0);
        chk("entry_num", 32'($signed(number)), 6);

        // First breathing cycle, then the wrap cycle.
        for (int j = 0; j < 10; j++) begin
            idle(SC);
            chk("breath1_bri", 32'(brightness), seq[j]);
            chk("breath1_num", 32'($signed(number)), (j == 9) ? 7 : 6);
        end
        for (int j = 0; j < 10; j++) begin
            idle(SC);
            chk("breath2_bri", 32'(brightness), seq[j]);
        end
        chk("breath_wrap", 32'($signed(number)), -8);

        // Up to brightness 3 on the way down, then exit with dim.
        for (int j = 0; j < 7; j++) begin
            idle(SC);
            chk("breath3_bri", 32'(brightness), seq[j]);
        end
        chk("down_auto", 32'(auto_active), 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("exit_auto", 32'(auto_active), 0);
        chk("exit_num", 32'($signed(number)), 6);
        chk("exit_bri", 32'(brightness), 2);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_exit_dim", 32'(brightness), 1);

        // Tick collides with the entering step event.
        idle(11);
        chk("collide_pre_auto", 32'(auto_active), 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("collide_auto", 32'(auto_active), 0);
        chk("collide_bri", 32'(brightness), 0);
        idle(11);
        chk("deferred_pre_auto", 32'(auto_active), 0);
        idle(1);
        chk("deferred_auto", 32'(auto_active), 1);
        idle(SC);
        chk("up_bri", 32'(brightness), 1);

        // Asynchronous reset while in AUTO_UP.
        #3 reset_n = 1'b0;
        #1 check_reset_values("rst_auto");
        model_reset();
        @(posedge clk);
        #1 check_reset_values("rst_auto_held");
        reset_n = 1'b1;

        // Randomized tick stream against the model.
        repeat (800) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                p = 4'($urandom_range(1, 15));
                if (r < 2) begin
                    repeat ($urandom_range(2, 6)) cycle(p[3], p[2], p[1], p[0]);
                end else begin
                    cycle(p[3], p[2], p[1], p[0]);
                end
            end else begin
                cycle(1'b0, 1'b0, 1'b0, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
